// File: rtl/bcd_counter_pkg.sv
// Shared types and constants for the BCD counter: digit width, decade limit,
// and the nibble sanitiser applied on parallel load.
package bcd_counter_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef logic [BCD_W-1:0] digit_t;

    // Non-decimal nibbles are loaded as zero so digits never leave 0..9.
    function automatic digit_t bcd_sanitize(input digit_t d);
        return (d > BCD_MAX) ? digit_t'(0) : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD chain: holds a single 0..9 digit and propagates
// carry (counting up) or borrow (counting down) to the next decade.
module bcd_digit
    import bcd_counter_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   step,
    input  logic   up,
    input  logic   cin,
    input  logic   load,
    input  digit_t load_d,
    input  logic   clear,
    output digit_t digit,
    output logic   cout
);

    digit_t digit_q;
    digit_t digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clear) begin
            digit_d = '0;
        end else if (load) begin
            digit_d = bcd_sanitize(load_d);
        end else if (step && cin) begin
            if (up) begin
                digit_d = (digit_q == BCD_MAX) ? digit_t'(0) : digit_q + digit_t'(1);
            end else begin
                digit_d = (digit_q == digit_t'(0)) ? BCD_MAX : digit_q - digit_t'(1);
            end
        end
    end

    // Carry/borrow leaves this decade only when it is about to wrap.
    assign cout  = step && cin && (up ? (digit_q == BCD_MAX) : (digit_q == digit_t'(0)));
    assign digit = digit_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/bcd_counter.sv
// Multi-decade BCD up/down counter with clock prescaler, synchronous clear
// and parallel load; tick/carry pulses align with the updated count.
module bcd_counter
    import bcd_counter_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tick,
    output logic                  carry
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q;
    logic [PS_W-1:0] ps_d;
    logic            tick_q;
    logic            tick_d;
    logic            carry_q;
    logic            carry_d;
    logic            step;
    logic            load_eff;
    logic [DIGITS:0] chain;

    // clear outranks load, and either one suppresses a coincident step.
    assign load_eff = load && !clear;
    assign step     = en && (ps_q == PS_LAST) && !clear && !load;
    assign chain[0] = step;

    always_comb begin
        ps_d    = ps_q;
        tick_d  = 1'b0;
        carry_d = 1'b0;
        if (clear || load) begin
            ps_d = '0;
        end else if (en) begin
            ps_d    = (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);
            tick_d  = step;
            carry_d = chain[DIGITS];
        end
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            digit_t digit_w;

            bcd_digit u_digit (
                .clk    (clk),
                .rst    (rst),
                .step   (step),
                .up     (up),
                .cin    (chain[gi]),
                .load   (load_eff),
                .load_d (load_val[gi*BCD_W +: BCD_W]),
                .clear  (clear),
                .digit  (digit_w),
                .cout   (chain[gi+1])
            );

            assign count[gi*BCD_W +: BCD_W] = digit_w;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_q    <= '0;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            ps_q    <= ps_d;
            tick_q  <= tick_d;
            carry_q <= carry_d;
        end
    end

    assign tick  = tick_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_bcd_counter.sv
// Self-checking bench for bcd_counter: directed scenarios plus randomized
// traffic, compared against a decimal-integer reference model.
module tb_bcd_counter;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 4;
    localparam int MODULUS  = 10000;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                en = 1'b0;
    logic                up = 1'b1;
    logic                clear = 1'b0;
    logic                load = 1'b0;
    logic [4*DIGITS-1:0] load_val = '0;
    logic [4*DIGITS-1:0] count;
    logic                tick;
    logic                carry;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: plain decimal value and prescaler phase.
    int m_val = 0;
    int m_ps  = 0;
    bit m_tick  = 1'b0;
    bit m_carry = 1'b0;

    bcd_counter #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tick     (tick),
        .carry    (carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int load_decimal(input logic [4*DIGITS-1:0] lv);
        int v;
        int w;
        int nib;
        v = 0;
        w = 1;
        for (int i = 0; i < DIGITS; i++) begin
            nib = int'(lv[i*4 +: 4]);
            if (nib > 9) nib = 0;
            v = v + nib * w;
            w = w * 10;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_val   = 0;
        m_ps    = 0;
        m_tick  = 1'b0;
        m_carry = 1'b0;
    endtask

    task automatic model_update();
        m_tick  = 1'b0;
        m_carry = 1'b0;
        if (clear) begin
            m_val = 0;
            m_ps  = 0;
        end else if (load) begin
            m_val = load_decimal(load_val);
            m_ps  = 0;
        end else if (en) begin
            if (m_ps == PRESCALE - 1) begin
                m_ps   = 0;
                m_tick = 1'b1;
                if (up) begin
                    m_carry = (m_val == MODULUS - 1);
                    m_val   = (m_val + 1) % MODULUS;
                end else begin
                    m_carry = (m_val == 0);
                    m_val   = (m_val + MODULUS - 1) % MODULUS;
                end
            end else begin
                m_ps++;
            end
        end
    endtask

    // One clock: update the model with the inputs seen at the edge, then
    // compare all outputs 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
        check("count", 32'(count), 32'(to_bcd(m_val)));
        check("tick",  32'(tick),  32'(m_tick));
        check("carry", 32'(carry), 32'(m_carry));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_load(input logic [4*DIGITS-1:0] v);
        load_val = v;
        load = 1'b1;
        cyc();
        load = 1'b0;
        $display("txn load 0x%04h -> count 0x%04h", v, count);
    endtask

    // Reset asserted between edges must clear outputs with no clock edge.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_count", 32'(count), 32'h0);
        check("rst_tick",  32'(tick),  32'h0);
        check("rst_carry", 32'(carry), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("txn async reset");
    endtask

    initial begin
        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("por_count", 32'(count), 32'h0);
        check("por_tick",  32'(tick),  32'h0);
        check("por_carry", 32'(carry), 32'h0);
        rst = 1'b0;

        // Reset mid-count, then first tick exactly PRESCALE cycles later.
        en = 1'b1;
        up = 1'b1;
        cycles(6);
        check("pre_rst_count", 32'(count), 32'h1);
        async_reset();
        cycles(PRESCALE - 1);
        check("no_early_tick", 32'(tick), 32'h0);
        cyc();
        check("first_tick", 32'(tick), 32'h1);
        check("first_count", 32'(count), 32'h1);
        $display("txn reset/first-tick done");

        // Up with full wrap.
        do_load(16'h9998);
        cycles(PRESCALE);
        check("up_9999", 32'(count), 32'h9999);
        cycles(PRESCALE);
        check("wrap_count", 32'(count), 32'h0000);
        check("wrap_carry", 32'(carry), 32'h1);
        cyc();
        check("carry_one_cycle", 32'(carry), 32'h0);
        $display("txn up wrap done");

        // Down with borrow and full wrap.
        up = 1'b0;
        do_load(16'h1000);
        cycles(PRESCALE);
        check("down_0999", 32'(count), 32'h0999);
        check("down_nocarry", 32'(carry), 32'h0);
        do_load(16'h0000);
        cycles(PRESCALE);
        check("down_wrap", 32'(count), 32'h9999);
        check("down_carry", 32'(carry), 32'h1);
        $display("txn down borrow done");

        // Invalid nibbles load as zero.
        en = 1'b0;
        do_load(16'h3AF7);
        check("invalid_load", 32'(count), 32'h3007);

        // Enable hold: prescaler freezes and resumes where it stopped.
        up = 1'b1;
        do_load(16'h0000);
        en = 1'b1;
        cycles(2);
        en = 1'b0;
        cycles(10);
        en = 1'b1;
        cyc();
        check("hold_no_tick", 32'(tick), 32'h0);
        cyc();
        check("hold_tick", 32'(tick), 32'h1);
        check("hold_count", 32'(count), 32'h0001);
        $display("txn enable hold done");

        // Priority at terminal count.
        do_load(16'h1234);
        cycles(PRESCALE - 1);
        clear = 1'b1;
        load = 1'b1;
        load_val = 16'h5678;
        cyc();
        clear = 1'b0;
        load = 1'b0;
        check("prio_clear_count", 32'(count), 32'h0);
        check("prio_clear_tick", 32'(tick), 32'h0);
        cycles(PRESCALE - 1);
        do_load(16'h0042);
        check("prio_load_count", 32'(count), 32'h0042);
        check("prio_load_tick", 32'(tick), 32'h0);
        $display("txn priority done");

        // Randomized traffic; clear/load/reset kept rare so steps dominate.
        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom_range(3) != 0);
            up       = 1'($urandom_range(1));
            clear    = ($urandom_range(63) == 0);
            load     = ($urandom_range(31) == 0);
            load_val = ($urandom_range(1) == 0) ? 16'($urandom)
                                                : to_bcd(($urandom_range(1) == 0) ? 0 : 9999);
            cyc();
            if (clear || load)
                $display("txn rand clear=%0d load=%0d val=0x%04h -> count 0x%04h",
                         clear, load, load_val, count);
            if ($urandom_range(499) == 0) async_reset();
        end
        clear = 1'b0;
        load  = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_counter.md
# bcd_counter

Multi-digit decimal counter that produces the 4-bit BCD digit values consumed by the seven-segment decoders, one decoder per digit. A prescaler divides the system clock down to a count tick; on each tick the digit chain increments or decrements with decade carry/borrow. Synchronous clear and parallel load let the surrounding logic reset or preset the displayed value.

## Interface
- DIGITS, 4, number of BCD decades (1..8)
- PRESCALE, 50_000_000, clock cycles per count tick (≥2); sims use 4
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable; low freezes prescaler and digits
- up  in  1  direction: 1 = count up, 0 = count down
- clear  in  1  synchronous clear of digits and prescaler
- load  in  1  synchronous parallel load strobe
- load_val  in  4*DIGITS  preset value, digit 0 in bits [3:0]
- count  out  4*DIGITS  current BCD value, digit 0 (least significant) in bits [3:0]
- tick  out  1  one-cycle pulse, high in the cycle the new count is presented
- carry  out  1  one-cycle pulse on full-range wrap (up: all-9 → 0; down: 0 → all-9)

## Operation
- Reset: count = 0, prescaler = 0, tick = 0, carry = 0.
- Priority per cycle: clear > load > count tick.
- clear: count = 0, prescaler = 0, tick = 0, carry = 0; independent of en.
- load: each nibble of load_val copied to its digit; any nibble > 9 is loaded as 0. Prescaler reset to 0; tick/carry = 0. Independent of en.
- Prescaler: when en = 1 and no clear/load, increments 0..PRESCALE-1; at PRESCALE-1 it returns to 0 and a count step occurs on the same edge. When en = 0, prescaler holds its value (no restart on re-enable).
- Count step, up: digit 0 increments; a digit at 9 goes to 0 and passes carry to the next digit. Step down: digit 0 decrements; a digit at 0 goes to 9 and passes borrow.
- carry asserted when the carry/borrow leaves the most significant digit (value wraps 9999→0000 or 0000→9999 for DIGITS=4).
- up may change at any time; it is sampled only on the step edge.
- Digits never hold values > 9 by construction.

## Timing
- count, tick, carry are registered outputs; no combinational path from any input to any output.
- First step after clear/load/reset with en held high: PRESCALE cycles later (count changes on the PRESCALE-th rising edge with en = 1).
- tick and carry high for exactly one cycle, aligned with the updated count.
- clear or load in the same cycle as a prescaler terminal count: step is suppressed, tick = 0.
- en deasserted in the terminal cycle: no step; step occurs when en next high at terminal.
- rst asserted mid-operation: all outputs to reset values immediately, independent of clk.

## Structure
- Shared package: BCD_W = 4, BCD_MAX = 4'd9, digit type (4-bit logic).
- Sub-module bcd_digit: one decade; inputs step, up, cin (carry/borrow in), load, load_d, clear; outputs digit and cout. Instantiated DIGITS times in a generate chain; digit 0 cin tied to the prescaler step.
- Top holds the prescaler (width $clog2(PRESCALE)), priority logic, and tick/carry registers.

## Test plan
- Reset: rst pulse mid-count with PRESCALE=4 → count = 0, tick = 0, carry = 0 immediately; first tick 4 cycles after release with en = 1.
- Up with wrap: load 0x9998, up = 1, en = 1 → 0x9999 after 4 cycles, then 0x0000 with tick = 1 and carry = 1 for one cycle.
- Down with borrow: load 0x1000, up = 0 → next step 0x0999 (carry = 0); load 0x0000 → next step 0x9999 with carry = 1.
- Invalid load: load_val = 0x3AF7 → count = 0x3007.
- Enable hold: en low after 2 prescaler cycles for 10 cycles, then high → step occurs exactly 2 cycles after re-enable, count +1.
- Priority: clear and load together at terminal count → count = 0, tick = 0; load alone at terminal → count = load_val, no step.
